// File: rtl/row_matmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : row_matmul_arbiter
// Brief    : Round-robin sharing of one row-by-matrix multiplier between
//            NUM_REQ requesters, with an ID tag pipeline matching its latency.
// Revision : 1.0
// ============================================================================
module row_matmul_arbiter #(
    parameter int W          = 16,
    parameter int IN_D       = 4,
    parameter int OUT_D      = 8,
    parameter int NUM_REQ    = 4,
    parameter int MM_LATENCY = 3,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_v,
    input  logic [NUM_REQ*IN_D*W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [IN_D*W-1:0]           mm_packed_a,
    input  logic [2*OUT_D*W-1:0]        mm_packed_out,
    input  logic                        mm_out_v,
    output logic                        res_v,
    output logic [ID_W-1:0]             res_id,
    output logic [2*OUT_D*W-1:0]        res_data,
    output logic                        busy,
    output logic                        err_latency
);

    localparam int c_ROW_W = IN_D * W;

    logic [ID_W-1:0]       r_rr_ptr;
    logic [MM_LATENCY:0]   r_tag_v;
    logic [ID_W-1:0]       r_tag_id [0:MM_LATENCY];

    logic                  w_hi_v;
    logic [ID_W-1:0]       w_hi_id;
    logic                  w_lo_v;
    logic [ID_W-1:0]       w_lo_id;
    logic                  w_grant_v;
    logic [ID_W-1:0]       w_grant_id;
    logic [ID_W-1:0]       w_next_ptr;
    logic [c_ROW_W-1:0]    w_row;
    logic                  w_retire_ok;
    logic                  w_retire_bad;

    // Two priority scans: first requester at or above the pointer wins,
    // otherwise wrap around to the lowest requester.
    always_comb begin
        w_hi_v  = 1'b0;
        w_hi_id = '0;
        w_lo_v  = 1'b0;
        w_lo_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_hi_v && req_v[i] && (i >= int'(r_rr_ptr))) begin
                w_hi_v  = 1'b1;
                w_hi_id = ID_W'(i);
            end
            if (!w_lo_v && req_v[i]) begin
                w_lo_v  = 1'b1;
                w_lo_id = ID_W'(i);
            end
        end
        w_grant_v  = w_hi_v | w_lo_v;
        w_grant_id = w_hi_v ? w_hi_id : w_lo_id;
        w_next_ptr = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        w_row     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_v && (w_grant_id == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                w_row        = req_data[i*c_ROW_W +: c_ROW_W];
            end
        end
    end

    assign w_retire_ok  = r_tag_v[MM_LATENCY] &  mm_out_v;
    assign w_retire_bad = r_tag_v[MM_LATENCY] & ~mm_out_v;
    assign busy         = |r_tag_v;

    // Stage 0 travels with mm_packed_a; stage MM_LATENCY lines up with mm_packed_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            mm_packed_a <= '0;
            r_tag_v     <= '0;
            for (int k = 0; k <= MM_LATENCY; k++) begin
                r_tag_id[k] <= '0;
            end
            res_v       <= 1'b0;
            res_id      <= '0;
            res_data    <= '0;
            err_latency <= 1'b0;
        end else begin
            if (w_grant_v) begin
                r_rr_ptr <= w_next_ptr;
            end
            mm_packed_a <= w_row;
            r_tag_v     <= {r_tag_v[MM_LATENCY-1:0], w_grant_v};
            r_tag_id[0] <= w_grant_id;
            for (int k = 1; k <= MM_LATENCY; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
            res_v <= w_retire_ok;
            if (w_retire_ok) begin
                res_id   <= r_tag_id[MM_LATENCY];
                res_data <= mm_packed_out;
            end
            if (w_retire_bad) begin
                err_latency <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_row_matmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_matmul_arbiter
// Brief    : Self-checking bench with a fixed-latency multiplier stand-in and
//            a cycle-indexed reference model of grants and results.
// Revision : 1.0
// ============================================================================
module tb_row_matmul_arbiter;

    localparam int W          = 16;
    localparam int IN_D       = 4;
    localparam int OUT_D      = 8;
    localparam int NUM_REQ    = 4;
    localparam int MM_LATENCY = 3;
    localparam int ID_W       = 2;
    localparam int c_ROW_W    = IN_D * W;
    localparam int c_RES_W    = 2 * OUT_D * W;
    localparam int c_NCYC     = 1024;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_v;
    logic [NUM_REQ*c_ROW_W-1:0]  req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic [c_ROW_W-1:0]          mm_packed_a;
    logic [c_RES_W-1:0]          mm_packed_out;
    logic                        mm_out_v;
    logic                        res_v;
    logic [ID_W-1:0]             res_id;
    logic [c_RES_W-1:0]          res_data;
    logic                        busy;
    logic                        err_latency;

    row_matmul_arbiter #(
        .W(W), .IN_D(IN_D), .OUT_D(OUT_D), .NUM_REQ(NUM_REQ),
        .MM_LATENCY(MM_LATENCY), .ID_W(ID_W)
    ) u_dut (
        .clk(clk), .rst(rst), .req_v(req_v), .req_data(req_data),
        .req_ready(req_ready), .mm_packed_a(mm_packed_a),
        .mm_packed_out(mm_packed_out), .mm_out_v(mm_out_v),
        .res_v(res_v), .res_id(res_id), .res_data(res_data),
        .busy(busy), .err_latency(err_latency)
    );

    always #5 clk = ~clk;

    // Signed row x fixed matrix B, each column accumulated in 2*W bits.
    function automatic logic [c_RES_W-1:0] matmul(input logic [c_ROW_W-1:0] row);
        logic [c_RES_W-1:0]      r;
        logic signed [2*W-1:0]   acc, a_e, b_e;
        r = '0;
        for (int j = 0; j < OUT_D; j++) begin
            acc = '0;
            for (int i = 0; i < IN_D; i++) begin
                a_e = (2*W)'($signed(row[i*W +: W]));
                b_e = (2*W)'(i * 3 - j * 5 + 2);
                acc = acc + a_e * b_e;
            end
            r[j*2*W +: 2*W] = acc;
        end
        return r;
    endfunction

    // Multiplier stand-in: result of the row presented MM_LATENCY cycles ago.
    logic [c_ROW_W-1:0] dly [0:MM_LATENCY-1];
    always @(posedge clk) begin
        dly[0] <= mm_packed_a;
        for (int k = 1; k < MM_LATENCY; k++) dly[k] <= dly[k-1];
    end
    assign mm_packed_out = matmul(dly[MM_LATENCY-1]);

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [c_RES_W-1:0] obs,
                             input logic [c_RES_W-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: per-cycle expectations, indexed by cycle number.
    bit                 iss     [c_NCYC];
    int                 iss_id  [c_NCYC];
    bit [c_ROW_W-1:0]   iss_row [c_NCYC];
    bit                 e_rv    [c_NCYC];
    int                 e_id    [c_NCYC];
    bit [c_RES_W-1:0]   e_data  [c_NCYC];
    bit [c_ROW_W-1:0]   e_a     [c_NCYC];
    bit                 e_err   [c_NCYC];
    bit                 e_rst   [c_NCYC];
    int                 m_ptr  = 0;
    bit                 m_err  = 0;
    int                 h_id   = 0;
    bit [c_RES_W-1:0]   h_data = '0;
    int                 cyc    = 0;
    bit                 fixed_en = 0;
    logic [c_ROW_W-1:0] fixed_row;

    task automatic step(input bit rst_i, input logic [NUM_REQ-1:0] v, input bit zero);
        int c, g, k, idx;
        bit bz;
        logic [NUM_REQ-1:0] exp_rdy;
        @(posedge clk);
        #1;
        c = cyc;
        cyc++;
        if (e_rst[c]) begin
            m_err  = 0;
            h_id   = 0;
            h_data = '0;
        end
        if (e_err[c]) m_err = 1;
        if (e_rv[c]) begin
            h_id   = e_id[c];
            h_data = e_data[c];
        end
        bz = 0;
        for (int j = c - 1 - MM_LATENCY; j <= c - 1; j++)
            if (j >= 0 && iss[j]) bz = 1;
        check_val("res_v", res_v, e_rv[c]);
        check_val("res_id", res_id, h_id[ID_W-1:0]);
        check_val("res_data", res_data, h_data);
        check_val("err_latency", err_latency, m_err);
        check_val("busy", busy, bz);
        check_val("mm_packed_a", mm_packed_a, e_a[c]);

        rst      = rst_i;
        req_v    = v;
        for (int i = 0; i < NUM_REQ; i++)
            req_data[i*c_ROW_W +: c_ROW_W] = fixed_en ? fixed_row : {$urandom, $urandom};
        mm_out_v = !zero;
        #1;
        g = -1;
        for (int n = 0; n < NUM_REQ; n++) begin
            idx = (m_ptr + n) % NUM_REQ;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_val("req_ready", req_ready, exp_rdy);

        k = c - 1 - MM_LATENCY;
        if (rst_i) begin
            m_ptr = 0;
            for (int j = 0; j <= c; j++) iss[j] = 0;
            e_rst[c+1] = 1;
        end else begin
            if (k >= 0 && iss[k]) begin
                if (zero) e_err[c+1] = 1;
                else begin
                    e_rv[c+1]   = 1;
                    e_id[c+1]   = iss_id[k];
                    e_data[c+1] = matmul(iss_row[k]);
                end
            end
            if (g >= 0) begin
                iss[c]     = 1;
                iss_id[c]  = g;
                iss_row[c] = req_data[g*c_ROW_W +: c_ROW_W];
                e_a[c+1]   = req_data[g*c_ROW_W +: c_ROW_W];
                m_ptr      = (g + 1) % NUM_REQ;
            end
        end
    endtask

    initial begin
        logic [NUM_REQ-1:0] rv;
        bit rr;
        rst      = 1'b1;
        req_v    = '0;
        req_data = '0;
        mm_out_v = 1'b1;
        e_rst[0] = 1;
        step(1, '0, 0);
        step(1, '0, 0);

        // single row 1,2,3,4 from requester 2
        fixed_en  = 1;
        fixed_row = {16'd4, 16'd3, 16'd2, 16'd1};
        step(0, 4'b0100, 0);
        fixed_en  = 0;
        repeat (7) step(0, '0, 0);

        // saturation
        repeat (8) step(0, 4'hF, 0);
        repeat (7) step(0, '0, 0);

        // fairness between 0 and 3
        repeat (6) step(0, 4'b1001, 0);
        repeat (6) step(0, '0, 0);

        // bubbles
        step(0, 4'b0010, 0);
        step(0, '0, 0);
        step(0, 4'b0010, 0);
        step(0, 4'b1000, 0);
        repeat (7) step(0, '0, 0);

        // latency fault on the first row's retire cycle
        step(0, 4'b0001, 0);
        step(0, 4'b0100, 0);
        step(0, '0, 0);
        step(0, '0, 0);
        step(0, '0, 1);
        repeat (6) step(0, '0, 0);

        // reset with rows in flight
        repeat (3) step(0, 4'hF, 0);
        step(0, '0, 0);
        step(1, '0, 0);
        step(0, 4'b0110, 0);
        repeat (8) step(0, '0, 0);

        // random traffic with occasional faults and resets
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom % 60) == 0;
            rv = rr ? '0 : NUM_REQ'($urandom);
            step(rr, rv, ($urandom % 16) == 0);
        end
        repeat (8) step(0, '0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
